// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package loader_pkg;

  localparam int BYTE_W     = 8;
  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    RUN,
    WAIT_LEN,
    RECV,
    WRITE,
    RELEASE,
    ERR
  } loader_state_t;

endpackage

// File: rtl/rx_word_packer.sv
// Packs a stream of bytes into little-endian 32-bit words, lane 0 first.
module rx_word_packer
  import loader_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         byte_valid,
  input  logic [BYTE_W-1:0]            byte_in,
  output logic [WORD_BYTES*BYTE_W-1:0] word,
  output logic                         word_done
);

  logic [WORD_BYTES-1:0][BYTE_W-1:0] lanes;
  logic [WORD_BYTES-1:0][BYTE_W-1:0] lanes_ins;
  logic [1:0]                        byte_idx;

  // Current byte is inserted combinationally so the completed word is
  // available in the same cycle as its last byte.
  always_comb begin
    lanes_ins = lanes;
    if (byte_valid) lanes_ins[byte_idx] = byte_in;
  end

  assign word      = lanes_ins;
  assign word_done = byte_valid && (byte_idx == 2'(WORD_BYTES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      byte_idx <= '0;
      lanes    <= '0;
    end else if (byte_valid) begin
      lanes    <= lanes_ins;
      byte_idx <= byte_idx + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Owns the instruction-memory port: forwards the fetch PC in normal operation
// and writes a UART-delivered program from address 0 while holding the core in reset.
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              start_load,
  input  logic [31:0]       pc_addr,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_din,
  output logic              imem_web,
  output logic              imem_csb,
  output logic              core_rst,
  output logic              load_done,
  output logic              load_err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  loader_state_t     state;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W:0]   words_left;
  logic [CNT_W-1:0]  idle;
  logic [31:0]       wdata;

  logic        last_word;
  logic        pk_accept;
  logic        pk_clear;
  logic [31:0] pk_word;
  logic        pk_done;
  logic        idle_tc;
  logic        len_bad;
  logic        unused_pc;

  assign last_word = (words_left == (ADDR_W + 1)'(1));
  assign idle_tc   = (idle == CNT_W'(TIMEOUT - 1));
  assign len_bad   = (rx_data == 8'd0) || (int'(rx_data) > DEPTH);

  // A byte arriving during a non-final WRITE starts the next word; during the
  // final WRITE it is dropped.
  assign pk_accept = rx_valid && ((state == RECV) || (state == WRITE && !last_word));
  assign pk_clear  = !((state == RECV) || (state == WRITE));

  rx_word_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (pk_clear),
    .byte_valid (pk_accept),
    .byte_in    (rx_data),
    .word       (pk_word),
    .word_done  (pk_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= RUN;
      waddr      <= '0;
      words_left <= '0;
      idle       <= '0;
      wdata      <= '0;
    end else begin
      case (state)
        RUN: begin
          idle <= '0;
          if (start_load) state <= WAIT_LEN;
        end
        WAIT_LEN: begin
          if (rx_valid) begin
            idle <= '0;
            if (len_bad) begin
              state <= ERR;
            end else begin
              words_left <= (ADDR_W + 1)'(rx_data);
              waddr      <= '0;
              state      <= RECV;
            end
          end else if (idle_tc) begin
            idle  <= '0;
            state <= ERR;
          end else begin
            idle <= idle + CNT_W'(1);
          end
        end
        RECV: begin
          if (rx_valid) begin
            idle <= '0;
            if (pk_done) begin
              wdata <= pk_word;
              state <= WRITE;
            end
          end else if (idle_tc) begin
            idle  <= '0;
            state <= ERR;
          end else begin
            idle <= idle + CNT_W'(1);
          end
        end
        WRITE: begin
          idle       <= '0;
          waddr      <= waddr + ADDR_W'(1);
          words_left <= words_left - (ADDR_W + 1)'(1);
          state      <= last_word ? RELEASE : RECV;
        end
        RELEASE: begin
          idle  <= '0;
          state <= RUN;
        end
        ERR: begin
          idle <= '0;
          if (start_load) state <= WAIT_LEN;
        end
        default: state <= RUN;
      endcase
    end
  end

  assign imem_addr = (state == RUN) ? pc_addr[ADDR_W+1:2] : waddr;
  assign imem_din  = wdata;
  // Synchronous reset still suppresses a write in the cycle it is asserted.
  assign imem_web  = !((state == WRITE) && rst_n);
  assign imem_csb  = 1'b0;
  assign core_rst  = (state != RUN);
  assign load_done = (state == RELEASE);
  assign load_err  = (state == ERR);

  assign unused_pc = ^{pc_addr[31:ADDR_W+2], pc_addr[1:0]};

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: PC forwarding, program loads, errors, timeout, reset.
module tb_imem_loader;

  localparam int ADDR_W  = 5;
  localparam int TIMEOUT = 20;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              start_load;
  logic [31:0]       pc_addr;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_din;
  logic              imem_web;
  logic              imem_csb;
  logic              core_rst;
  logic              load_done;
  logic              load_err;

  imem_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .start_load (start_load),
    .pc_addr    (pc_addr),
    .imem_addr  (imem_addr),
    .imem_din   (imem_din),
    .imem_web   (imem_web),
    .imem_csb   (imem_csb),
    .core_rst   (core_rst),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  logic [31:0] mem [1 << ADDR_W];

  // SRAM model: capture every write strobe seen at a rising edge.
  always @(posedge clk) begin
    if (!imem_web && !imem_csb) begin
      mem[imem_addr] = imem_din;
      wr_cnt++;
    end
    if (load_done) done_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start_load = 1'b1;
    step();
    start_load = 1'b0;
  endtask

  typedef struct {
    logic [31:0]       pc;
    logic [ADDR_W-1:0] exp_addr;
  } pc_vec_t;

  typedef struct {
    logic [7:0] len;
    logic       exp_err;
  } len_vec_t;

  pc_vec_t  pc_vecs  [6];
  len_vec_t len_vecs [4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int wr_base;

    pc_vecs[0] = '{32'h0000_0014, 5'd5};
    pc_vecs[1] = '{32'h0000_0000, 5'd0};
    pc_vecs[2] = '{32'h0000_007C, 5'd31};
    pc_vecs[3] = '{32'h0000_0080, 5'd0};
    pc_vecs[4] = '{32'hFFFF_FFFF, 5'd31};
    pc_vecs[5] = '{32'h0000_1236, 5'd13};

    len_vecs[0] = '{8'd0,   1'b1};
    len_vecs[1] = '{8'd33,  1'b1};
    len_vecs[2] = '{8'd64,  1'b1};
    len_vecs[3] = '{8'd255, 1'b1};

    rst_n      = 1'b0;
    rx_data    = '0;
    rx_valid   = 1'b0;
    start_load = 1'b0;
    pc_addr    = '0;
    step();
    step();
    check("rst_core_rst", 32'(core_rst), 32'd0);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_load_err", 32'(load_err), 32'd0);
    check("rst_web", 32'(imem_web), 32'd1);
    check("rst_din", imem_din, 32'd0);
    check("rst_csb", 32'(imem_csb), 32'd0);
    rst_n = 1'b1;
    step();

    // RUN: combinational PC forwarding, rx bytes ignored
    rx_valid = 1'b1;
    rx_data  = 8'hAA;
    for (int i = 0; i < 6; i++) begin
      pc_addr = pc_vecs[i].pc;
      #1;
      check($sformatf("run_addr[%0d]", i), 32'(imem_addr), 32'(pc_vecs[i].exp_addr));
      check($sformatf("run_web[%0d]", i), 32'(imem_web), 32'd1);
      check($sformatf("run_core_rst[%0d]", i), 32'(core_rst), 32'd0);
      step();
    end
    rx_valid = 1'b0;
    check("run_no_write", 32'(wr_cnt), 32'd0);

    // Normal two-word load with idle gaps
    pc_addr = 32'h0000_0014;
    wr_base = wr_cnt;
    pulse_start();
    check("load_core_rst_rise", 32'(core_rst), 32'd1);
    send_byte(8'd2);
    send_byte(8'h13); step();
    send_byte(8'h05); step();
    send_byte(8'h10);
    send_byte(8'h00);
    check("w0_web", 32'(imem_web), 32'd0);
    check("w0_addr", 32'(imem_addr), 32'd0);
    check("w0_din", imem_din, 32'h0010_0513);
    step();
    check("w0_web_after", 32'(imem_web), 32'd1);
    send_byte(8'hB3);
    send_byte(8'h85);
    send_byte(8'hA5);
    send_byte(8'h00);
    check("w1_addr", 32'(imem_addr), 32'd1);
    check("w1_din", imem_din, 32'h00A5_85B3);
    step();
    check("rel_load_done", 32'(load_done), 32'd1);
    check("rel_core_rst", 32'(core_rst), 32'd1);
    step();
    check("run_core_rst_fall", 32'(core_rst), 32'd0);
    check("run_load_done_low", 32'(load_done), 32'd0);
    check("run_addr_back", 32'(imem_addr), 32'd5);
    check("load_wr_cnt", 32'(wr_cnt - wr_base), 32'd2);
    check("load_done_cnt", 32'(done_cnt), 32'd1);
    check("mem0", mem[0], 32'h0010_0513);
    check("mem1", mem[1], 32'h00A5_85B3);

    // Byte arriving during WRITE of word 0 begins word 1; byte during final WRITE is dropped
    wr_base = wr_cnt;
    pulse_start();
    send_byte(8'd2);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    check("wc_w0_din", imem_din, 32'h4433_2211);
    send_byte(8'h55);
    send_byte(8'h66);
    send_byte(8'h77);
    send_byte(8'h88);
    check("wc_w1_web", 32'(imem_web), 32'd0);
    check("wc_w1_din", imem_din, 32'h8877_6655);
    send_byte(8'h99);
    check("wc_release", 32'(load_done), 32'd1);
    step();
    check("wc_run", 32'(core_rst), 32'd0);
    check("wc_mem0", mem[0], 32'h4433_2211);
    check("wc_mem1", mem[1], 32'h8877_6655);
    check("wc_wr_cnt", 32'(wr_cnt - wr_base), 32'd2);

    // Illegal lengths
    wr_base = wr_cnt;
    for (int i = 0; i < 4; i++) begin
      pulse_start();
      check($sformatf("len_err_cleared[%0d]", i), 32'(load_err), 32'd0);
      send_byte(len_vecs[i].len);
      check($sformatf("len_err[%0d]", i), 32'(load_err), 32'(len_vecs[i].exp_err));
      check($sformatf("len_core_rst[%0d]", i), 32'(core_rst), 32'd1);
      check($sformatf("len_web[%0d]", i), 32'(imem_web), 32'd1);
      step();
      check($sformatf("len_err_sticky[%0d]", i), 32'(load_err), 32'd1);
    end
    check("len_no_write", 32'(wr_cnt - wr_base), 32'd0);

    // Inter-byte timeout: ERR exactly TIMEOUT cycles after the last byte
    pulse_start();
    check("to_err_cleared", 32'(load_err), 32'd0);
    send_byte(8'd1);
    send_byte(8'hDE);
    send_byte(8'hAD);
    for (int i = 0; i < TIMEOUT - 1; i++) step();
    check("to_not_yet", 32'(load_err), 32'd0);
    step();
    check("to_err", 32'(load_err), 32'd1);
    check("to_core_rst", 32'(core_rst), 32'd1);
    check("to_no_write", 32'(wr_cnt - wr_base), 32'd0);

    // Reset during RECV
    pulse_start();
    send_byte(8'd2);
    send_byte(8'h01);
    send_byte(8'h02);
    rst_n = 1'b0;
    #1;
    check("mid_rst_web", 32'(imem_web), 32'd1);
    step();
    rst_n = 1'b1;
    check("mid_rst_core_rst", 32'(core_rst), 32'd0);
    check("mid_rst_load_err", 32'(load_err), 32'd0);
    check("mid_rst_web_after", 32'(imem_web), 32'd1);
    check("mid_rst_addr", 32'(imem_addr), 32'd5);
    step();
    check("mid_rst_no_write", 32'(wr_cnt - wr_base), 32'd0);
    check("mid_rst_mem0", mem[0], 32'h4433_2211);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
